// File: rtl/apb3_master_pkg.sv
// Shared types and helpers for the APB3 command master.
package apb3_master_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb3_master_state_e;

  // Default ACCESS-phase wait limit.
  localparam int APB3_TIMEOUT_CYCLES_DFLT = 256;

  // Timeout counter width; wide enough to hold the limit itself.
  localparam int APB3_TIMEOUT_CNT_W_DFLT = $clog2(APB3_TIMEOUT_CYCLES_DFLT + 1);

  // The same width rule, applied to any limit.
  function automatic int timeout_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb3_cmd_master.sv
// APB3 command master: turns a valid/ready command stream into APB3
// SETUP/ACCESS transfers. It returns one response per command, and only one
// transfer is outstanding at a time.
// Optional feature: define APB3_MASTER_TIMEOUT_EN to abort ACCESS phases
// that wait longer than TIMEOUT_CYCLES cycles.
module apb3_cmd_master
  import apb3_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = APB3_TIMEOUT_CYCLES_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  m_apb_psel,
  output logic                  m_apb_penable,
  output logic                  m_apb_pwrite,
  output logic [ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [DATA_WIDTH-1:0] m_apb_pwdata,
  input  logic [DATA_WIDTH-1:0] m_apb_prdata,
  input  logic                  m_apb_pready,
  input  logic                  m_apb_pslverr
);

  // A zero limit would abort before the completer can ever answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb3_cmd_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb3_master_state_e state_q, state_d;
  logic accept;
  logic complete;
  logic abort;

  // A new command is taken only when idle and no unconsumed response would be overwritten.
  assign cmd_ready = (state_q == APB_IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = (state_q == APB_ACCESS) && m_apb_pready;

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int TO_W = timeout_cnt_w(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // A completion in the limit cycle takes priority over the abort.
  assign abort = (state_q == APB_ACCESS) && !m_apb_pready &&
                 (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive ACCESS wait cycles; restart for each new transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if ((state_q == APB_ACCESS) && !m_apb_pready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  // Next-state logic: IDLE -> SETUP -> ACCESS (waits for PREADY) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE:   if (accept) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (complete || abort) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= APB_IDLE;
    else     state_q <= state_d;
  end

  // APB request signals. Address, data and direction are latched once and
  // stay stable for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
    end else begin
      if (accept) begin
        m_apb_psel   <= 1'b1;
        m_apb_pwrite <= cmd_write;
        m_apb_paddr  <= cmd_addr;
        m_apb_pwdata <= cmd_wdata;
      end
      if (state_q == APB_SETUP) m_apb_penable <= 1'b1;
      if (complete || abort) begin
        m_apb_psel    <= 1'b0;
        m_apb_penable <= 1'b0;
      end
    end
  end

  // One-entry response holding register; the contents are frozen until the consumer takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (complete) begin
      rsp_valid <= 1'b1;
      rsp_err   <= m_apb_pslverr;
      rsp_rdata <= m_apb_pwrite ? '0 : m_apb_prdata;
    end else if (abort) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_rdata <= '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Self-checking bench for apb3_cmd_master. Expected responses are queued
// when a command is issued and compared when the response appears.
// Define APB3_MASTER_TIMEOUT_EN to build the timeout scenarios.
module tb_apb3_cmd_master;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [AW-1:0] m_apb_paddr;
  logic [DW-1:0] m_apb_pwdata, m_apb_prdata;
  logic          m_apb_pready, m_apb_pslverr;

  int   total  = 0;
  int   passed = 0;
  rsp_t sb[$];

  apb3_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
    .m_apb_paddr(m_apb_paddr), .m_apb_pwdata(m_apb_pwdata), .m_apb_prdata(m_apb_prdata),
    .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; m_apb_prdata = '0; m_apb_pready = 0; m_apb_pslverr = 0;
    #1;
    total++; if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b000)
      $display("FAIL rst_apb_ctrl got=%b exp=000", {m_apb_psel, m_apb_penable, m_apb_pwrite});
    else passed++;
    total++; if ({m_apb_paddr, m_apb_pwdata} !== '0)
      $display("FAIL rst_apb_data got=%h/%h exp=0", m_apb_paddr, m_apb_pwdata);
    else passed++;
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0)
      $display("FAIL rst_rsp got=%b/%b/%h exp=0", rsp_valid, rsp_err, rsp_rdata);
    else passed++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Read with PREADY in the first ACCESS cycle; PREADY is already high during SETUP and must be ignored.
  task automatic test_read_basic();
    rsp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10; cmd_wdata = 32'h0; rsp_ready = 1;
    m_apb_pready = 1; m_apb_prdata = 32'h0BAD0BAD;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL t1_cmd_ready got=%b exp=1", cmd_ready);
    else passed++;
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0;
    total++; if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b100 || m_apb_paddr !== 32'h10)
      $display("FAIL t1_setup got=%b addr=%h exp=100 addr=10", {m_apb_psel, m_apb_penable, m_apb_pwrite}, m_apb_paddr);
    else passed++;
    m_apb_prdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if ({m_apb_psel, m_apb_penable, rsp_valid} !== 3'b110)
      $display("FAIL t1_access got=%b exp=110", {m_apb_psel, m_apb_penable, rsp_valid});
    else passed++;
    @(negedge clk);
    m_apb_pready = 0;
    total++; if ({rsp_valid, m_apb_psel, m_apb_penable} !== 3'b100)
      $display("FAIL t1_rsp_phase got=%b exp=100", {rsp_valid, m_apb_psel, m_apb_penable});
    else passed++;
    total++;
    if (sb.size() == 0) $display("FAIL t1_sb_empty got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t1_rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) $display("FAIL t1_rsp_clear got=%b exp=0", rsp_valid);
    else passed++;
  endtask

  // Write with three wait states; the request must stay stable across all four ACCESS cycles.
  task automatic test_write_wait();
    rsp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h04; cmd_wdata = 32'hA5A5A5A5;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0;
    m_apb_pready = 0; m_apb_prdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({m_apb_psel, m_apb_penable, m_apb_pwrite} !== 3'b111 ||
          m_apb_paddr !== 32'h04 || m_apb_pwdata !== 32'hA5A5A5A5 || rsp_valid !== 1'b0)
        $display("FAIL t2_access%0d got=%b %h %h v=%b exp=111 00000004 a5a5a5a5 v=0", i,
                 {m_apb_psel, m_apb_penable, m_apb_pwrite}, m_apb_paddr, m_apb_pwdata, rsp_valid);
      else passed++;
      m_apb_pready = (i == 3);
    end
    @(negedge clk);
    m_apb_pready = 0;
    total++;
    if (sb.size() == 0) $display("FAIL t2_sb_empty got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t2_rsp got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
  endtask

  // Read with PSLVERR, then a new command accepted in the same cycle the response is consumed.
  task automatic test_back_to_back();
    rsp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b1});
    @(negedge clk);
    cmd_valid = 0; m_apb_pready = 1; m_apb_pslverr = 1; m_apb_prdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    m_apb_pready = 0; m_apb_pslverr = 0;
    total++;
    if (sb.size() == 0) $display("FAIL t3_sb_empty got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t3_rsp_err got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h24; rsp_ready = 1;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL t3_b2b_ready got=%b exp=1", cmd_ready);
    else passed++;
    sb.push_back('{rdata: 32'h00000077, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0;
    total++;
    if ({m_apb_psel, m_apb_penable, rsp_valid} !== 3'b100 || m_apb_paddr !== 32'h24)
      $display("FAIL t3_b2b_setup got=%b addr=%h exp=100 addr=24", {m_apb_psel, m_apb_penable, rsp_valid}, m_apb_paddr);
    else passed++;
    m_apb_pready = 1; m_apb_prdata = 32'h00000077;
    @(negedge clk);
    @(negedge clk);
    m_apb_pready = 0;
    total++;
    if (sb.size() == 0) $display("FAIL t3_sb_empty2 got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t3_rsp2 got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
  endtask

  // Consumer stalls for 5 cycles while a command waits; response and cmd_ready must hold.
  task automatic test_rsp_backpressure();
    rsp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30; rsp_ready = 0;
    sb.push_back('{rdata: 32'h13579BDF, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0; m_apb_pready = 1; m_apb_prdata = 32'h13579BDF;
    @(negedge clk);
    @(negedge clk);
    m_apb_pready = 0; m_apb_prdata = 32'hFFFFFFFF;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h34; cmd_wdata = 32'h0F0F0F0F;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (sb.size() == 0) $display("FAIL t4_sb_empty got=0 exp=1 entries");
      else if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || m_apb_psel !== 1'b0 ||
               rsp_rdata !== sb[0].rdata || rsp_err !== sb[0].err)
        $display("FAIL t4_hold%0d got=rdy%b v%b sel%b %h/%b exp=rdy0 v1 sel0 %h/%b", i,
                 cmd_ready, rsp_valid, m_apb_psel, rsp_rdata, rsp_err, sb[0].rdata, sb[0].err);
      else passed++;
      @(negedge clk);
    end
    rsp_ready = 1;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL t4_release_ready got=%b exp=1", cmd_ready);
    else passed++;
    total++;
    if (sb.size() == 0) $display("FAIL t4_sb_empty2 got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t4_rsp got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0;
    total++;
    if ({m_apb_psel, m_apb_penable, m_apb_pwrite, rsp_valid} !== 4'b1010 || m_apb_paddr !== 32'h34)
      $display("FAIL t4_next_setup got=%b addr=%h exp=1010 addr=34",
               {m_apb_psel, m_apb_penable, m_apb_pwrite, rsp_valid}, m_apb_paddr);
    else passed++;
    m_apb_pready = 1;
    @(negedge clk);
    @(negedge clk);
    m_apb_pready = 0;
    total++;
    if (sb.size() == 0) $display("FAIL t4_sb_empty3 got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t4_rsp2 got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
  endtask

  // Reset asserted mid-ACCESS: the bus is dropped at once, the transfer is discarded and the FSM is reusable.
  task automatic test_reset_mid_access();
    rsp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h11112222;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0; m_apb_pready = 0;
    @(negedge clk);
    total++; if (m_apb_penable !== 1'b1) $display("FAIL t5_in_access got=%b exp=1", m_apb_penable);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({m_apb_psel, m_apb_penable, rsp_valid} !== 3'b000 || m_apb_paddr !== '0)
      $display("FAIL t5_async_drop got=%b addr=%h exp=000 addr=0", {m_apb_psel, m_apb_penable, rsp_valid}, m_apb_paddr);
    else passed++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL t5_idle_ready got=%b exp=1", cmd_ready);
    else passed++;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h44;
    sb.push_back('{rdata: 32'h44444444, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0;
    total++; if ({m_apb_psel, m_apb_penable} !== 2'b10)
      $display("FAIL t5_setup got=%b exp=10", {m_apb_psel, m_apb_penable});
    else passed++;
    m_apb_pready = 1; m_apb_prdata = 32'h44444444;
    @(negedge clk);
    @(negedge clk);
    m_apb_pready = 0;
    total++;
    if (sb.size() == 0) $display("FAIL t5_sb_empty got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t5_rsp got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
  endtask

`ifdef APB3_MASTER_TIMEOUT_EN
  // TIMEOUT_CYCLES=4: PREADY stuck low aborts; PREADY in the 4th ACCESS cycle completes normally.
  task automatic test_timeout();
    rsp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50 + 32'(pass);
      if (pass == 0) sb.push_back('{rdata: 32'h0, err: 1'b1});
      else           sb.push_back('{rdata: 32'h55AA55AA, err: 1'b0});
      @(negedge clk);
      cmd_valid = 0; m_apb_pready = 0; m_apb_prdata = (pass == 0) ? 32'hEEEEEEEE : 32'h55AA55AA;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        total++;
        if ({m_apb_psel, m_apb_penable, rsp_valid} !== 3'b110)
          $display("FAIL t6_access p%0d c%0d got=%b exp=110", pass, i, {m_apb_psel, m_apb_penable, rsp_valid});
        else passed++;
        m_apb_pready = (pass == 1) && (i == 3);
      end
      @(negedge clk);
      m_apb_pready = 0;
      total++;
      if (sb.size() == 0) $display("FAIL t6_sb_empty got=0 exp=1 entries");
      else begin
        e = sb.pop_front();
        if (rsp_valid !== 1'b1 || m_apb_psel !== 1'b0 || rsp_rdata !== e.rdata || rsp_err !== e.err)
          $display("FAIL t6_rsp p%0d got=%b sel%b %h/%b exp=1 sel0 %h/%b", pass,
                   rsp_valid, m_apb_psel, rsp_rdata, rsp_err, e.rdata, e.err);
        else passed++;
      end
    end
  endtask
`else
  // Without the timeout, a long ACCESS wait simply continues until PREADY.
  task automatic test_long_wait();
    rsp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h60;
    sb.push_back('{rdata: 32'h600DF00D, err: 1'b0});
    @(negedge clk);
    cmd_valid = 0; m_apb_pready = 0; m_apb_prdata = 32'h600DF00D;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({m_apb_psel, m_apb_penable, rsp_valid} !== 3'b110)
        $display("FAIL t6_wait c%0d got=%b exp=110", i, {m_apb_psel, m_apb_penable, rsp_valid});
      else passed++;
      m_apb_pready = (i == 9);
    end
    @(negedge clk);
    m_apb_pready = 0;
    total++;
    if (sb.size() == 0) $display("FAIL t6_sb_empty got=0 exp=1 entries");
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err)
        $display("FAIL t6_rsp got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_wait();
    test_back_to_back();
    test_rsp_backpressure();
    test_reset_mid_access();
`ifdef APB3_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    total++;
    if (sb.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
